// File: rtl/i2s_capture.sv
// i2s_capture
// Multi-line I2S receiver feeding the audio input DP RAM. Each sd line
// carries a stereo pair (left = channel 2n, right = channel 2n+1). Bit
// timing comes from the shared i2s_clock block (en strobe + frame_posn).
// At every frame end the captured samples are burst into RAM at
// {chan, frame}. The frame counter then advances and frame_done pulses
// so the sequencer can process the new frame.
module i2s_capture #(
    parameter int LINES   = 4,
    parameter int CHAN_W  = 3,
    parameter int FRAME_W = 8,
    parameter int WIDTH   = 16
) (
    input  logic                      ck_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic [5:0]                frame_posn_i,
    input  logic [LINES-1:0]          sd_i,
    input  logic                      capture_i,
    input  logic                      clr_overrun_i,
    output logic                      we_o,
    output logic [CHAN_W+FRAME_W-1:0] waddr_o,
    output logic [WIDTH-1:0]          wdata_o,
    output logic [FRAME_W-1:0]        frame_o,
    output logic                      frame_done_o,
    output logic                      overrun_o
);

    localparam int NCHAN = 2 * LINES;
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NCHAN - 1);

    // Burst sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // ------------------------------------------------------------------
    // Bit-position decode. Data bits sit one position after the word
    // select edge (I2S one-bit delay), so left occupies 1..16 and right
    // occupies 33..48. Position 63 marks the end of a frame.
    // ------------------------------------------------------------------
    logic shift_left;
    logic shift_right;
    logic frame_end;
    logic load_hold;

    assign shift_left  = en_i && (frame_posn_i >= 6'd1)  && (frame_posn_i <= 6'd16);
    assign shift_right = en_i && (frame_posn_i >= 6'd33) && (frame_posn_i <= 6'd48);
    assign frame_end   = en_i && (frame_posn_i == 6'd63) && capture_i;

    // Holding registers presented as one vector indexed by channel number.
    logic [NCHAN-1:0][WIDTH-1:0] hold_vec;

    // ------------------------------------------------------------------
    // Per-line deserialisers and holding registers. The holding copy is
    // what the burst reads, so the shift registers are free to start on
    // the next frame while the burst is still running.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            logic [WIDTH-1:0] left_sr_q;
            logic [WIDTH-1:0] right_sr_q;
            logic [WIDTH-1:0] hold_l_q;
            logic [WIDTH-1:0] hold_r_q;

            // Shift serial data MSB first during the active bit windows
            always_ff @(posedge ck_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    left_sr_q  <= '0;
                    right_sr_q <= '0;
                end else begin
                    if (shift_left) begin
                        left_sr_q <= {left_sr_q[WIDTH-2:0], sd_i[gi]};
                    end
                    if (shift_right) begin
                        right_sr_q <= {right_sr_q[WIDTH-2:0], sd_i[gi]};
                    end
                end
            end

            // Snapshot the completed samples when a burst is launched
            always_ff @(posedge ck_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hold_l_q <= '0;
                    hold_r_q <= '0;
                end else if (load_hold) begin
                    hold_l_q <= left_sr_q;
                    hold_r_q <= right_sr_q;
                end
            end

            assign hold_vec[2*gi]   = hold_l_q;
            assign hold_vec[2*gi+1] = hold_r_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Burst sequencer state
    // ------------------------------------------------------------------
    logic [1:0]                state_q,      state_d;
    logic [CHAN_W-1:0]         chan_q,       chan_d;
    logic [FRAME_W-1:0]        wframe_q,     wframe_d;
    logic [FRAME_W-1:0]        frame_q,      frame_d;
    logic                      we_q,         we_d;
    logic [CHAN_W+FRAME_W-1:0] waddr_q,      waddr_d;
    logic [WIDTH-1:0]          wdata_q,      wdata_d;
    logic                      frame_done_q, frame_done_d;
    logic                      overrun_q,    overrun_d;

    // Next-state logic: launch on frame end, stream channels, then publish
    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        wframe_d     = wframe_q;
        frame_d      = frame_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        load_hold    = 1'b0;

        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_end) begin
                    load_hold = 1'b1;
                    wframe_d  = frame_q + FRAME_W'(1);
                    chan_d    = '0;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                we_d    = 1'b1;
                waddr_d = {chan_q, wframe_q};
                wdata_d = hold_vec[chan_q];
                chan_d  = chan_q + CHAN_W'(1);
                if (chan_q == LAST_CHAN) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_d      = wframe_q;
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A frame end during a burst drops that frame; setting beats clearing
        if (frame_end && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Register sequencer state and all RAM-facing outputs
    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            chan_q       <= '0;
            wframe_q     <= '0;
            frame_q      <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            wframe_q     <= wframe_d;
            frame_q      <= frame_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign frame_o      = frame_q;
    assign frame_done_o = frame_done_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_i2s_capture.sv
// Testbench for i2s_capture: drives whole I2S frames carrying random or
// directed samples and checks each RAM burst against a sample-level model.
module tb_i2s_capture;

    localparam int LINES   = 4;
    localparam int CHAN_W  = 3;
    localparam int FRAME_W = 8;
    localparam int WIDTH   = 16;
    localparam int NCHAN   = 2 * LINES;

    logic                      ck = 1'b0;
    logic                      rst_ni;
    logic                      en_i;
    logic [5:0]                frame_posn_i;
    logic [LINES-1:0]          sd_i;
    logic                      capture_i;
    logic                      clr_overrun_i;
    logic                      we_o;
    logic [CHAN_W+FRAME_W-1:0] waddr_o;
    logic [WIDTH-1:0]          wdata_o;
    logic [FRAME_W-1:0]        frame_o;
    logic                      frame_done_o;
    logic                      overrun_o;

    always #5 ck = ~ck;

    i2s_capture #(
        .LINES  (LINES),
        .CHAN_W (CHAN_W),
        .FRAME_W(FRAME_W),
        .WIDTH  (WIDTH)
    ) dut (
        .ck_i         (ck),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .frame_posn_i (frame_posn_i),
        .sd_i         (sd_i),
        .capture_i    (capture_i),
        .clr_overrun_i(clr_overrun_i),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .frame_o      (frame_o),
        .frame_done_o (frame_done_o),
        .overrun_o    (overrun_o)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          exp_frame = 0;
    logic [15:0] smp [NCHAN];   // channel c sample: even = left of line c/2, odd = right

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic random_samples();
        for (int c = 0; c < NCHAN; c++) smp[c] = 16'($urandom);
    endtask

    // One frame: 64 bit positions, en high for one cycle out of two.
    task automatic drive_frame(input logic cap);
        for (int p = 0; p < 64; p++) begin
            @(negedge ck);
            en_i         = 1'b1;
            frame_posn_i = 6'(p);
            capture_i    = cap;
            for (int n = 0; n < LINES; n++) begin
                if (p >= 1 && p <= 16)       sd_i[n] = smp[2*n][16-p];
                else if (p >= 33 && p <= 48) sd_i[n] = smp[2*n+1][48-p];
                else                         sd_i[n] = 1'($urandom_range(0, 1));
            end
            @(negedge ck);
            en_i = 1'b0;
            sd_i = LINES'($urandom);
        end
    endtask

    // Called one negedge after the posn-63 strobe edge. Optionally injects
    // a second frame-end strobe (and a simultaneous overrun clear).
    task automatic check_burst(input int inject, input logic clr_with_inject);
        int wf;
        wf = (exp_frame + 1) % 256;
        check("we_latency", we_o, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge ck);
            en_i          = (k == inject);
            frame_posn_i  = (k == inject) ? 6'd63 : 6'd0;
            clr_overrun_i = (k == inject) && clr_with_inject;
            if (k <= NCHAN) begin
                check("we_burst", we_o, 1'b1);
                check("waddr", waddr_o, 32'((k - 1) * 256 + wf));
                check("wdata", wdata_o, smp[k-1]);
                check("done_early", frame_done_o, 1'b0);
            end else if (k == NCHAN + 1) begin
                check("we_after", we_o, 1'b0);
                check("frame_done", frame_done_o, 1'b1);
                check("frame", frame_o, wf);
            end else begin
                check("done_single", frame_done_o, 1'b0);
                check("we_idle", we_o, 1'b0);
            end
        end
        en_i          = 1'b0;
        clr_overrun_i = 1'b0;
        exp_frame     = wf;
        $display("burst frame=%0d written", wf);
    endtask

    task automatic check_idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge ck);
            check("idle_we", we_o, 1'b0);
            check("idle_done", frame_done_o, 1'b0);
        end
        check("idle_frame", frame_o, exp_frame);
        $display("idle %0d cycles frame=%0d", cycles, exp_frame);
    endtask

    initial begin
        rst_ni        = 1'b0;
        en_i          = 1'b0;
        frame_posn_i  = 6'd0;
        sd_i          = '0;
        capture_i     = 1'b1;
        clr_overrun_i = 1'b0;
        repeat (3) @(negedge ck);
        check("rst_we", we_o, 1'b0);
        check("rst_waddr", waddr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_frame", frame_o, 0);
        check("rst_done", frame_done_o, 1'b0);
        check("rst_overrun", overrun_o, 1'b0);
        rst_ni = 1'b1;

        // Directed samples on line 0 and line 3
        for (int c = 0; c < NCHAN; c++) smp[c] = 16'h0000;
        smp[0] = 16'hA5C3;
        smp[1] = 16'h1234;
        smp[6] = 16'h8001;
        drive_frame(1'b1);
        check_burst(0, 1'b0);

        // Random frame
        random_samples();
        drive_frame(1'b1);
        check_burst(0, 1'b0);
        check("no_overrun", overrun_o, 1'b0);

        // Second frame end 3 ck into a burst, with clear in the same cycle
        random_samples();
        drive_frame(1'b1);
        check_burst(2, 1'b1);
        check("overrun_set", overrun_o, 1'b1);
        check("overrun_frame", frame_o, exp_frame);
        @(negedge ck);
        clr_overrun_i = 1'b1;
        @(negedge ck);
        clr_overrun_i = 1'b0;
        check("overrun_clr", overrun_o, 1'b0);

        // Capture disabled for two frames, then re-enabled
        random_samples();
        drive_frame(1'b0);
        check_idle(12);
        random_samples();
        drive_frame(1'b0);
        check_idle(12);
        check("cap_off_overrun", overrun_o, 1'b0);
        random_samples();
        drive_frame(1'b1);
        check_burst(0, 1'b0);

        // Long run across the frame counter wrap
        for (int f = 0; f < 257; f++) begin
            random_samples();
            drive_frame(1'b1);
            check_burst(0, 1'b0);
        end
        check("long_overrun", overrun_o, 1'b0);

        // Reset in the middle of a burst
        random_samples();
        drive_frame(1'b1);
        for (int k = 1; k <= 5; k++) @(negedge ck);
        check("pre_rst_waddr", waddr_o, 32'(4 * 256 + (exp_frame + 1) % 256));
        #1 rst_ni = 1'b0;
        #1;
        check("arst_we", we_o, 1'b0);
        check("arst_waddr", waddr_o, 0);
        check("arst_wdata", wdata_o, 0);
        check("arst_frame", frame_o, 0);
        @(negedge ck);
        rst_ni    = 1'b1;
        exp_frame = 0;
        check_idle(12);
        check("post_rst_overrun", overrun_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
